// File: rtl/stump_reg_write_arbiter_pkg.sv
// Shared definitions for the Stump register-bank write arbiter: requester ids,
// register-file constants and a saturating counter helper.
package stump_pkg;

  localparam int NUM_REGS = 8;
  localparam int PC_REG   = 7;
  localparam int ZERO_REG = 0;
  localparam int STAT_W   = 16;

  typedef logic [1:0] req_id_t;

  localparam req_id_t REQ_EXE = 2'd0;
  localparam req_id_t REQ_MEM = 2'd1;
  localparam req_id_t REQ_DBG = 2'd2;

  function automatic req_id_t next_req(input req_id_t r);
    return (r == REQ_DBG) ? REQ_EXE : req_id_t'(r + 2'd1);
  endfunction

  function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v);
    return (v == {STAT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/stump_rr_arb3.sv
// Combinational 3-way round-robin picker. The search starts at i_ptr and wraps
// EXE->MEM->DBG; with i_lock set only the DBG request is eligible.
module stump_rr_arb3
  import stump_pkg::*;
(
  input  logic [2:0] i_req,
  input  req_id_t    i_ptr,
  input  logic       i_lock,
  output logic [2:0] o_grant
);

  logic [2:0] w_elig;

  assign w_elig = i_lock ? (i_req & 3'b100) : i_req;

  // Walk the order backwards so the requester closest to the pointer wins.
  always_comb begin
    o_grant = 3'b000;
    for (int i = 2; i >= 0; i--) begin
      if (w_elig[(int'(i_ptr) + i) % 3]) begin
        o_grant = 3'b001 << ((int'(i_ptr) + i) % 3);
      end
    end
  end

endmodule

// File: rtl/stump_reg_write_arbiter.sv
// Owns the Stump register-bank write port: round-robin arbitration of EXE, MEM
// and DBG, a registered write stage and the pending-write busy scoreboard.
// Optional statistics counters are built when STUMP_REGARB_STATS_EN is defined.
module stump_reg_write_arbiter
  import stump_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              exe_valid,
  output logic              exe_ready,
  input  logic [ADDR_W-1:0] exe_addr,
  input  logic [DATA_W-1:0] exe_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              dbg_valid,
  output logic              dbg_ready,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_data,
  input  logic              dbg_lock,
  input  logic              claim_valid,
  input  logic [ADDR_W-1:0] claim_addr,
  output logic [7:0]        busy,
  output logic              write_en,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [15:0]       stat_exe,
  output logic [15:0]       stat_mem,
  output logic [15:0]       stat_dbg,
  output logic [15:0]       stat_r0_drop
);

  // Handshake: a requester raises valid and holds addr/data stable until its
  // ready is high; the write is taken on the edge where valid && ready.
  logic [2:0]        w_grant;
  logic              w_xfer;
  logic              w_drop;
  req_id_t           w_gid;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_data;
  logic [7:0]        w_busy_nxt;

  req_id_t           r_ptr;
  logic              r_write_en;
  logic [ADDR_W-1:0] r_write_addr;
  logic [DATA_W-1:0] r_write_data;
  logic [7:0]        r_busy;

  stump_rr_arb3 u_arb (
    .i_req   ({dbg_valid, mem_valid, exe_valid}),
    .i_ptr   (r_ptr),
    .i_lock  (dbg_lock),
    .o_grant (w_grant)
  );

  assign exe_ready = w_grant[0];
  assign mem_ready = w_grant[1];
  assign dbg_ready = w_grant[2];
  assign w_xfer    = |w_grant;

  always_comb begin
    w_gid  = REQ_EXE;
    w_addr = exe_addr;
    w_data = exe_data;
    if (w_grant[1]) begin
      w_gid  = REQ_MEM;
      w_addr = mem_addr;
      w_data = mem_data;
    end else if (w_grant[2]) begin
      w_gid  = REQ_DBG;
      w_addr = dbg_addr;
      w_data = dbg_data;
    end
  end

  assign w_drop = w_xfer && (w_addr == ADDR_W'(ZERO_REG));

  // Clear on write first, then set on claim so a same-cycle claim wins.
  always_comb begin
    w_busy_nxt = r_busy;
    for (int n = 0; n < NUM_REGS; n++) begin
      if (w_xfer && (w_addr == ADDR_W'(n))) w_busy_nxt[n] = 1'b0;
      if (claim_valid && (claim_addr == ADDR_W'(n))) w_busy_nxt[n] = 1'b1;
    end
    w_busy_nxt[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ptr        <= REQ_EXE;
      r_write_en   <= 1'b0;
      r_write_addr <= '0;
      r_write_data <= '0;
      r_busy       <= 8'h00;
    end else begin
      r_write_en <= w_xfer && !w_drop;
      r_busy     <= w_busy_nxt;
      if (w_xfer && !w_drop) begin
        r_write_addr <= w_addr;
        r_write_data <= w_data;
      end
      if (w_xfer && !dbg_lock) r_ptr <= next_req(w_gid);
    end
  end

  assign write_en   = r_write_en;
  assign write_addr = r_write_addr;
  assign write_data = r_write_data;
  assign busy       = r_busy;

`ifdef STUMP_REGARB_STATS_EN
  logic [15:0] r_stat_exe;
  logic [15:0] r_stat_mem;
  logic [15:0] r_stat_dbg;
  logic [15:0] r_stat_r0_drop;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_exe     <= '0;
      r_stat_mem     <= '0;
      r_stat_dbg     <= '0;
      r_stat_r0_drop <= '0;
    end else begin
      if (w_grant[0]) r_stat_exe <= sat_inc(r_stat_exe);
      if (w_grant[1]) r_stat_mem <= sat_inc(r_stat_mem);
      if (w_grant[2]) r_stat_dbg <= sat_inc(r_stat_dbg);
      if (w_drop)     r_stat_r0_drop <= sat_inc(r_stat_r0_drop);
    end
  end

  assign stat_exe     = r_stat_exe;
  assign stat_mem     = r_stat_mem;
  assign stat_dbg     = r_stat_dbg;
  assign stat_r0_drop = r_stat_r0_drop;
`else
  assign stat_exe     = 16'h0000;
  assign stat_mem     = 16'h0000;
  assign stat_dbg     = 16'h0000;
  assign stat_r0_drop = 16'h0000;
`endif

endmodule

// File: tb/tb_stump_reg_write_arbiter.sv
// Bench for stump_reg_write_arbiter: directed test-plan cases plus randomized
// traffic checked against a queue-based reference model of the arbiter.
module tb_stump_reg_write_arbiter;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int QW = 1 + AW + DW + 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          exe_valid, mem_valid, dbg_valid;
  logic          exe_ready, mem_ready, dbg_ready;
  logic [AW-1:0] exe_addr, mem_addr, dbg_addr, claim_addr;
  logic [DW-1:0] exe_data, mem_data, dbg_data;
  logic          dbg_lock, claim_valid;
  logic [7:0]    busy;
  logic          write_en;
  logic [AW-1:0] write_addr;
  logic [DW-1:0] write_data;
  logic [15:0]   stat_exe, stat_mem, stat_dbg, stat_r0_drop;
  logic [2:0]    rdy_v;

  int errors = 0;
  int checks = 0;
  logic [QW-1:0] exp_q[$];

  // Reference model state
  int            m_ptr;
  logic [7:0]    m_busy;
  logic [AW-1:0] m_waddr;
  logic [DW-1:0] m_wdata;
  int            m_cnt[3];
  int            m_drop;
  logic [2:0]    g_last;

  stump_reg_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst),
    .exe_valid(exe_valid), .exe_ready(exe_ready), .exe_addr(exe_addr), .exe_data(exe_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
    .dbg_valid(dbg_valid), .dbg_ready(dbg_ready), .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .dbg_lock(dbg_lock), .claim_valid(claim_valid), .claim_addr(claim_addr),
    .busy(busy), .write_en(write_en), .write_addr(write_addr), .write_data(write_data),
    .stat_exe(stat_exe), .stat_mem(stat_mem), .stat_dbg(stat_dbg), .stat_r0_drop(stat_r0_drop)
  );

  assign rdy_v = {dbg_ready, mem_ready, exe_ready};

  // Clock / reset block
  always #5 clk = ~clk;

  task automatic model_reset();
    exp_q.delete();
    m_ptr   = 0;
    m_busy  = 8'h00;
    m_waddr = '0;
    m_wdata = '0;
    m_drop  = 0;
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
    g_last  = 3'b000;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    exe_valid = 1'b0; mem_valid = 1'b0; dbg_valid = 1'b0;
    dbg_lock = 1'b0; claim_valid = 1'b0;
  endtask

  task automatic drive_all(input logic [AW-1:0] ae, input logic [AW-1:0] am, input logic [AW-1:0] ad);
    exe_valid = 1'b1; exe_addr = ae; exe_data = DW'($urandom);
    mem_valid = 1'b1; mem_addr = am; mem_data = DW'($urandom);
    dbg_valid = 1'b1; dbg_addr = ad; dbg_data = DW'($urandom);
  endtask

  // New requests only start once the previous one was granted.
  task automatic drive_rand();
    if (!exe_valid || g_last[0]) begin
      exe_valid = ($urandom_range(0, 3) != 0);
      exe_addr  = AW'($urandom_range(0, 7));
      exe_data  = DW'($urandom);
    end
    if (!mem_valid || g_last[1]) begin
      mem_valid = ($urandom_range(0, 3) != 0);
      mem_addr  = AW'($urandom_range(0, 7));
      mem_data  = DW'($urandom);
    end
    if (!dbg_valid || g_last[2]) begin
      dbg_valid = ($urandom_range(0, 2) == 0);
      dbg_addr  = AW'($urandom_range(0, 7));
      dbg_data  = DW'($urandom);
    end
    dbg_lock    = ($urandom_range(0, 15) == 0);
    claim_valid = ($urandom_range(0, 3) == 0);
    claim_addr  = AW'($urandom_range(0, 7));
  endtask

  // Reference model: pick the first valid requester in rotating order from the
  // pointer, then push the expected write-stage/busy state for the next edge.
  always @(negedge clk) begin
    if (!rst) begin
      int            g;
      int            k;
      logic          v[3];
      logic [AW-1:0] a[3];
      logic [DW-1:0] d[3];
      logic [2:0]    exp_rdy;
      logic          en;
      v[0] = exe_valid; a[0] = exe_addr; d[0] = exe_data;
      v[1] = mem_valid; a[1] = mem_addr; d[1] = mem_data;
      v[2] = dbg_valid; a[2] = dbg_addr; d[2] = dbg_data;
      g = -1;
      for (int i = 0; i < 3; i++) begin
        k = (m_ptr + i) % 3;
        if (g < 0 && v[k] && (!dbg_lock || k == 2)) g = k;
      end
      exp_rdy = (g < 0) ? 3'b000 : 3'(1 << g);
      chk("ready_vec", 32'(rdy_v), 32'(exp_rdy));
      g_last = exp_rdy;
      en = 1'b0;
      if (g >= 0) begin
        if (!dbg_lock) m_ptr = (g + 1) % 3;
        if (m_cnt[g] < 65535) m_cnt[g]++;
        if (a[g] == 0) begin
          if (m_drop < 65535) m_drop++;
        end else begin
          en      = 1'b1;
          m_waddr = a[g];
          m_wdata = d[g];
        end
        m_busy[a[g]] = 1'b0;
      end
      if (claim_valid && claim_addr != 0) m_busy[claim_addr] = 1'b1;
      exp_q.push_back({en, m_waddr, m_wdata, m_busy});
    end
  end

  // Monitor: after each edge compare the registered outputs to the model.
  always @(posedge clk) begin
    #3;
    if (!rst && exp_q.size() > 0) begin
      logic [QW-1:0] e;
      e = exp_q.pop_front();
      chk("write_stage", 32'({write_en, write_addr, write_data, busy}), 32'(e));
    end
  end

  initial begin
    logic [2:0] ord[6];
    int         exp_stat[4];
    ord = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
    idle_inputs();
    exe_addr = '0; mem_addr = '0; dbg_addr = '0; claim_addr = '0;
    exe_data = '0; mem_data = '0; dbg_data = '0;
    do_reset();

    chk("rst_wen", 32'(write_en), 32'(0));
    chk("rst_waddr", 32'(write_addr), 32'(0));
    chk("rst_wdata", 32'(write_data), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready", 32'(rdy_v), 32'(0));
    chk("rst_stats", 32'(stat_exe | stat_mem | stat_dbg | stat_r0_drop), 32'(0));

    // Single EXE write
    exe_valid = 1'b1; exe_addr = 3'd3; exe_data = 16'hBEEF;
    @(negedge clk);
    chk("exe_ready_same_cycle", 32'(exe_ready), 32'(1));
    step();
    exe_valid = 1'b0;
    #1;
    chk("single_wen", 32'(write_en), 32'(1));
    chk("single_waddr", 32'(write_addr), 32'(3));
    chk("single_wdata", 32'(write_data), 32'(16'hBEEF));

    // Round-robin burst from a fresh pointer
    do_reset();
    drive_all(3'd1, 3'd2, 3'd4);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("rr_order", 32'(rdy_v), 32'(ord[i]));
      step();
      #1;
      chk("b2b_wen", 32'(write_en), 32'(1));
    end
    idle_inputs();

    // Debug lock holds off EXE/MEM and leaves the pointer alone
    step();
    drive_all(3'd1, 3'd2, 3'd4);
    dbg_lock = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lock_grant", 32'(rdy_v), 32'(3'b100));
      step();
    end
    dbg_lock = 1'b0; dbg_valid = 1'b0;
    @(negedge clk);
    chk("post_lock_grant", 32'(rdy_v), 32'(3'b001));
    step();
    idle_inputs();

    // Scoreboard claim / clear
    claim_valid = 1'b1; claim_addr = 3'd5;
    step();
    claim_valid = 1'b0;
    #1;
    chk("claim_busy", 32'(busy), 32'(8'h20));
    mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 16'h1234;
    claim_valid = 1'b1; claim_addr = 3'd5;
    step();
    mem_valid = 1'b0; claim_valid = 1'b0;
    #1;
    chk("claim_wins", 32'(busy), 32'(8'h20));
    mem_valid = 1'b1; mem_addr = 3'd5; mem_data = 16'h5678;
    step();
    mem_valid = 1'b0;
    #1;
    chk("write_clears", 32'(busy), 32'(8'h00));

    // Write to r0 is accepted and dropped
    dbg_valid = 1'b1; dbg_addr = 3'd0; dbg_data = 16'hDEAD;
    @(negedge clk);
    chk("r0_ready", 32'(dbg_ready), 32'(1));
    step();
    dbg_valid = 1'b0;
    #1;
    chk("r0_wen", 32'(write_en), 32'(0));
    chk("r0_hold_addr", 32'(write_addr), 32'(5));
    chk("r0_hold_data", 32'(write_data), 32'(16'h5678));
`ifdef STUMP_REGARB_STATS_EN
    chk("r0_drop_stat", 32'(stat_r0_drop), 32'(1));
`else
    chk("r0_drop_stat", 32'(stat_r0_drop), 32'(0));
`endif

    // Randomized traffic
    for (int c = 0; c < 1500; c++) begin
      drive_rand();
      step();
    end
    idle_inputs();
    step();
    step();
`ifdef STUMP_REGARB_STATS_EN
    exp_stat = '{m_cnt[0], m_cnt[1], m_cnt[2], m_drop};
`else
    exp_stat = '{0, 0, 0, 0};
`endif
    chk("stat_exe", 32'(stat_exe), 32'(exp_stat[0]));
    chk("stat_mem", 32'(stat_mem), 32'(exp_stat[1]));
    chk("stat_dbg", 32'(stat_dbg), 32'(exp_stat[2]));
    chk("stat_r0_drop", 32'(stat_r0_drop), 32'(exp_stat[3]));

    // Asynchronous reset in the middle of a burst
    drive_all(3'd1, 3'd2, 3'd4);
    claim_valid = 1'b1; claim_addr = 3'd6;
    step();
    step();
    @(negedge clk);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    chk("async_rst_wen", 32'(write_en), 32'(0));
    chk("async_rst_busy", 32'(busy), 32'(0));
    claim_valid = 1'b0;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("first_after_rst", 32'(rdy_v), 32'(3'b001));
    step();
    idle_inputs();
    repeat (3) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
